// File: rtl/pc_unit.sv
// PC and fetch control: resolves branch/JAL/JALR redirects and misaligned-target traps; redirect reaches fetch_addr 1 cycle after an ack in FETCH.
// fetch_addr is held while fetch_req waits for fetch_ack; stall only blocks sequential advance, never a redirect.
module pc_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_is_jal,
   input  logic        ex_is_jalr,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_imm,
   input  logic        alu_branch,
   input  logic [31:0] alu_result,
   output logic        fetch_req,
   output logic [31:0] fetch_addr,
   input  logic        fetch_ack,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic        flush,
   output logic        trap,
   output logic [31:0] trap_tval
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] pending, pending_nxt;
   logic        if_valid_nxt, flush_nxt, trap_nxt;

   logic        taken;
   logic [31:0] target;
   logic        misaligned;
   logic [31:0] next_pc;

   assign taken      = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & alu_branch));
   assign target     = ex_is_jalr ? (alu_result & ~32'h1) : (ex_pc + ex_imm);
   assign misaligned = target[1:0] != 2'b00;
   assign next_pc    = misaligned ? TRAP_VECTOR : target;

   // In DRAIN the outstanding request keeps the old pc until memory acks it.
   assign fetch_req  = (state == FETCH) || (state == DRAIN);
   assign fetch_addr = pc;

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      pending_nxt  = pending;
      if_valid_nxt = 1'b0;
      flush_nxt    = 1'b0;
      trap_nxt     = 1'b0;
      unique case (state)
         BOOT: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            if (taken) begin
               flush_nxt = 1'b1;
               trap_nxt  = misaligned;
               if (fetch_ack) begin
                  pc_nxt = next_pc;
               end else begin
                  pending_nxt = next_pc;
                  state_nxt   = DRAIN;
               end
            end else if (fetch_ack && !stall) begin
               if_valid_nxt = 1'b1;
               pc_nxt       = pc + 32'd4;
            end
         end
         DRAIN: begin
            // Youngest redirect wins; the drained word is always discarded.
            if (taken) begin
               flush_nxt   = 1'b1;
               trap_nxt    = misaligned;
               pending_nxt = next_pc;
            end
            if (fetch_ack) begin
               pc_nxt    = taken ? next_pc : pending;
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= BOOT;
         pc        <= RESET_VECTOR;
         pending   <= RESET_VECTOR;
         if_valid  <= 1'b0;
         if_pc     <= 32'h0;
         flush     <= 1'b0;
         trap      <= 1'b0;
         trap_tval <= 32'h0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         pending  <= pending_nxt;
         if_valid <= if_valid_nxt;
         flush    <= flush_nxt;
         trap     <= trap_nxt;
         if (if_valid_nxt) begin
            if_pc <= pc;
         end
         if (trap_nxt) begin
            trap_tval <= target;
         end
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: hand-computed expectations checked one cycle at a time.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
   logic [31:0] ex_pc, ex_imm, alu_result;
   logic        alu_branch;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ack;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        flush, trap;
   logic [31:0] trap_tval;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
      .ex_is_jalr(ex_is_jalr), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .alu_branch(alu_branch), .alu_result(alu_result),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
      .if_valid(if_valid), .if_pc(if_pc), .flush(flush), .trap(trap),
      .trap_tval(trap_tval)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ex();
      ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
      alu_branch = 0; ex_pc = 0; ex_imm = 0; alu_result = 0;
   endtask

   task automatic jal(input logic [31:0] pc_v, input logic [31:0] imm_v);
      clear_ex();
      ex_valid = 1; ex_is_jal = 1; ex_pc = pc_v; ex_imm = imm_v;
   endtask

   initial begin
      rst_n = 0; stall = 0; fetch_ack = 1;
      clear_ex();
      step(); step();
      check("rst_req", {31'b0, fetch_req}, 32'h0);
      check("rst_addr", fetch_addr, 32'h0);
      check("rst_ifv", {31'b0, if_valid}, 32'h0);
      check("rst_ifpc", if_pc, 32'h0);
      check("rst_tval", trap_tval, 32'h0);

      // boot cycle then sequential fetch
      rst_n = 1;
      check("boot_req", {31'b0, fetch_req}, 32'h0);
      step();
      check("f0_req", {31'b0, fetch_req}, 32'h1);
      check("f0_addr", fetch_addr, 32'h0);
      check("f0_ifv", {31'b0, if_valid}, 32'h0);
      step();
      check("f1_addr", fetch_addr, 32'h4);
      check("f1_ifv", {31'b0, if_valid}, 32'h1);
      check("f1_ifpc", if_pc, 32'h0);
      step();
      check("f2_addr", fetch_addr, 32'h8);
      check("f2_ifpc", if_pc, 32'h4);

      // memory wait at 0x8
      fetch_ack = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("wait_addr", fetch_addr, 32'h8);
         check("wait_ifv", {31'b0, if_valid}, 32'h0);
      end
      fetch_ack = 1;
      step();
      check("wack_ifv", {31'b0, if_valid}, 32'h1);
      check("wack_ifpc", if_pc, 32'h8);
      check("wack_addr", fetch_addr, 32'hC);

      // taken branch 0x10 + (-8)
      clear_ex();
      ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h10; ex_imm = 32'hFFFF_FFF8; alu_branch = 1;
      step();
      check("br_flush", {31'b0, flush}, 32'h1);
      check("br_ifv", {31'b0, if_valid}, 32'h0);
      check("br_addr", fetch_addr, 32'h8);
      alu_branch = 0;
      step();
      check("nbr_flush", {31'b0, flush}, 32'h0);
      check("nbr_ifpc", if_pc, 32'h8);
      check("nbr_addr", fetch_addr, 32'hC);

      // JALR clears bit 0
      clear_ex();
      ex_valid = 1; ex_is_jalr = 1; alu_result = 32'h201; ex_pc = 32'h10; ex_imm = 32'h6;
      step();
      check("jalr_addr", fetch_addr, 32'h200);
      check("jalr_trap", {31'b0, trap}, 32'h0);
      check("jalr_flush", {31'b0, flush}, 32'h1);

      // misaligned JAL traps
      jal(32'h10, 32'h6);
      step();
      check("trap_pulse", {31'b0, trap}, 32'h1);
      check("trap_tval", trap_tval, 32'h16);
      check("trap_addr", fetch_addr, 32'h100);
      clear_ex();
      step();
      check("trap_end", {31'b0, trap}, 32'h0);
      check("tval_hold", trap_tval, 32'h16);
      check("trap_ifpc", if_pc, 32'h100);
      check("trap_next", fetch_addr, 32'h104);

      // redirect during outstanding request, then newer redirect in DRAIN
      jal(32'h40, 32'h0);
      step();
      check("to40", fetch_addr, 32'h40);
      fetch_ack = 0;
      jal(32'h40, 32'h40);
      step();
      check("dr_flush", {31'b0, flush}, 32'h1);
      check("dr_addr", fetch_addr, 32'h40);
      check("dr_req", {31'b0, fetch_req}, 32'h1);
      clear_ex();
      step();
      check("dr_hold", fetch_addr, 32'h40);
      check("dr_flush0", {31'b0, flush}, 32'h0);
      jal(32'h80, 32'h40);
      step();
      check("dr2_flush", {31'b0, flush}, 32'h1);
      check("dr2_addr", fetch_addr, 32'h40);
      clear_ex();
      fetch_ack = 1;
      step();
      check("dr_ack_ifv", {31'b0, if_valid}, 32'h0);
      check("dr_ack_addr", fetch_addr, 32'hC0);
      step();
      check("c0_ifpc", if_pc, 32'hC0);
      check("c0_next", fetch_addr, 32'hC4);

      // stall does not block redirect, but blocks advance
      stall = 1;
      jal(32'h0, 32'h20);
      step();
      check("st_flush", {31'b0, flush}, 32'h1);
      check("st_addr", fetch_addr, 32'h20);
      clear_ex();
      step();
      check("st_ifv", {31'b0, if_valid}, 32'h0);
      check("st_hold", fetch_addr, 32'h20);
      stall = 0;
      step();
      check("st_rel_ifv", {31'b0, if_valid}, 32'h1);
      check("st_rel_ifpc", if_pc, 32'h20);
      check("st_rel_addr", fetch_addr, 32'h24);

      // wrap at 2^32
      jal(32'hFFFF_FFF0, 32'hC);
      step();
      check("wrap_pre", fetch_addr, 32'hFFFF_FFFC);
      clear_ex();
      step();
      check("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
      check("wrap_addr", fetch_addr, 32'h0);

      // async reset in DRAIN
      fetch_ack = 0;
      jal(32'h0, 32'h80);
      step();
      check("rd_flush", {31'b0, flush}, 32'h1);
      clear_ex();
      #2;
      rst_n = 0;
      #1;
      check("ar_req", {31'b0, fetch_req}, 32'h0);
      check("ar_flush", {31'b0, flush}, 32'h0);
      check("ar_tval", trap_tval, 32'h0);
      check("ar_ifpc", if_pc, 32'h0);
      check("ar_addr", fetch_addr, 32'h0);
      step();
      fetch_ack = 1;
      rst_n = 1;
      step();
      check("ar_rel_req", {31'b0, fetch_req}, 32'h1);
      check("ar_rel_ifv", {31'b0, if_valid}, 32'h0);
      step();
      check("ar_rel_ifpc", if_pc, 32'h0);
      check("ar_rel_addr", fetch_addr, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
